// File: rtl/instruction_decode_if.sv
// Fetch-side and execute-side handshakes of the decode stage, bundled into one interface.
// The master modport is the environment's view; the slave modport is the decode stage's view.
interface instruction_decode_if #(
  parameter int PC_W = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic [PC_W-1:0] in_pc;

  logic            out_valid;
  logic            out_ready;
  logic [3:0]      out_cond;
  logic [2:0]      out_class;
  logic [3:0]      out_dp_op;
  logic            out_s;
  logic [3:0]      out_rn;
  logic [3:0]      out_rd;
  logic [3:0]      out_rm;
  logic [7:0]      out_shift;
  logic [3:0]      out_rot;
  logic [7:0]      out_imm8;
  logic [11:0]     out_off12;
  logic            out_ld;
  logic            out_up;
  logic [PC_W-1:0] out_pc;
  logic [PC_W-1:0] out_br_target;

  modport master (
    output in_valid, in_instr, in_pc, out_ready,
    input  in_ready, out_valid, out_cond, out_class, out_dp_op, out_s,
           out_rn, out_rd, out_rm, out_shift, out_rot, out_imm8, out_off12,
           out_ld, out_up, out_pc, out_br_target
  );

  modport slave (
    input  in_valid, in_instr, in_pc, out_ready,
    output in_ready, out_valid, out_cond, out_class, out_dp_op, out_s,
           out_rn, out_rd, out_rm, out_shift, out_rot, out_imm8, out_off12,
           out_ld, out_up, out_pc, out_br_target
  );
endinterface

// File: rtl/instruction_decode_stage.sv
// Registered ARM-subset decode stage: decode on accept, DEPTH-entry FIFO, drain to execute.
// Optional macro DECODE_UNDEF_CNT_EN adds a saturating undefined-instruction counter port.
module instruction_decode_stage #(
  parameter int PC_W  = 32,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 flush,
  instruction_decode_if.slave  bus
`ifdef DECODE_UNDEF_CNT_EN
  ,
  output logic [CNT_W-1:0]     undef_cnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = DEPTH[AW:0];
  localparam logic [AW-1:0] PTR_ONE  = 1;

  typedef enum logic [2:0] {
    CLS_DP_REG = 3'd0,
    CLS_DP_IMM = 3'd1,
    CLS_LDST   = 3'd2,
    CLS_B      = 3'd3,
    CLS_BL     = 3'd4,
    CLS_UNDEF  = 3'd7
  } cls_e;

  typedef struct packed {
    logic [3:0]      cond;
    cls_e            cls;
    logic [3:0]      dp_op;
    logic            s;
    logic [3:0]      rn;
    logic [3:0]      rd;
    logic [3:0]      rm;
    logic [7:0]      shift;
    logic [3:0]      rot;
    logic [7:0]      imm8;
    logic [11:0]     off12;
    logic            ld;
    logic            up;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] br_target;
  } entry_t;

  entry_t          dec;
  entry_t          head;
  entry_t          mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [AW:0]     count;
  logic            push;
  logic            pop;
  logic [7:0]      op;
  logic [31:0]     boff;
  logic [PC_W-1:0] target;

  assign op   = bus.in_instr[27:20];
  // Word offset, pre-shifted by 2 and sign-extended to 32 bits before resizing to PC_W.
  assign boff = {{6{bus.in_instr[23]}}, bus.in_instr[23:0], 2'b00};
  assign target = bus.in_pc + PC_W'(8) + PC_W'(signed'(boff));

  always_comb begin
    dec      = '0;
    dec.cond = bus.in_instr[31:28];
    dec.pc   = bus.in_pc;
    unique case (op[7:5])
      3'b000:  dec.cls = CLS_DP_REG;
      3'b001:  dec.cls = CLS_DP_IMM;
      3'b010:  dec.cls = CLS_LDST;
      3'b011:  dec.cls = bus.in_instr[4] ? CLS_UNDEF : CLS_LDST;
      3'b101:  dec.cls = op[4] ? CLS_BL : CLS_B;
      default: dec.cls = CLS_UNDEF;
    endcase

    case (dec.cls)
      CLS_DP_REG: begin
        dec.dp_op = bus.in_instr[24:21];
        dec.s     = bus.in_instr[20];
        dec.rn    = bus.in_instr[19:16];
        dec.rd    = bus.in_instr[15:12];
        dec.rm    = bus.in_instr[3:0];
        dec.shift = bus.in_instr[11:4];
      end
      CLS_DP_IMM: begin
        dec.dp_op = bus.in_instr[24:21];
        dec.s     = bus.in_instr[20];
        dec.rn    = bus.in_instr[19:16];
        dec.rd    = bus.in_instr[15:12];
        dec.rot   = bus.in_instr[11:8];
        dec.imm8  = bus.in_instr[7:0];
      end
      CLS_LDST: begin
        dec.rn    = bus.in_instr[19:16];
        dec.rd    = bus.in_instr[15:12];
        dec.rm    = bus.in_instr[3:0];
        dec.shift = bus.in_instr[11:4];
        dec.off12 = bus.in_instr[11:0];
        dec.ld    = bus.in_instr[20];
        dec.up    = bus.in_instr[23];
      end
      CLS_B, CLS_BL: dec.br_target = target;
      default: ;
    endcase
  end

  assign bus.in_ready  = (count < CNT_FULL);
  assign bus.out_valid = (count != '0);
  assign push = bus.in_valid && bus.in_ready;
  assign pop  = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
      case ({push, pop})
        2'b10:   count <= count + CNT_ONE;
        2'b01:   count <= count - CNT_ONE;
        default: count <= count;
      endcase
    end
  end

  // Storage needs no reset: the head is masked to zero whenever count is zero.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= dec;
  end

  assign head = bus.out_valid ? mem[rd_ptr] : '0;

  assign bus.out_cond      = head.cond;
  assign bus.out_class     = head.cls;
  assign bus.out_dp_op     = head.dp_op;
  assign bus.out_s         = head.s;
  assign bus.out_rn        = head.rn;
  assign bus.out_rd        = head.rd;
  assign bus.out_rm        = head.rm;
  assign bus.out_shift     = head.shift;
  assign bus.out_rot       = head.rot;
  assign bus.out_imm8      = head.imm8;
  assign bus.out_off12     = head.off12;
  assign bus.out_ld        = head.ld;
  assign bus.out_up        = head.up;
  assign bus.out_pc        = head.pc;
  assign bus.out_br_target = head.br_target;

`ifdef DECODE_UNDEF_CNT_EN
  localparam logic [CNT_W-1:0] UCNT_ONE = 1;

  // A push dropped by flush never reaches the buffer, so it is not counted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      undef_cnt <= '0;
    end else if (push && !flush && dec.cls == CLS_UNDEF && undef_cnt != '1) begin
      undef_cnt <= undef_cnt + UCNT_ONE;
    end
  end
`endif

endmodule

// File: tb/tb_instruction_decode_stage.sv
// Self-checking bench for instruction_decode_stage: directed scenarios plus a random run
// compared against a queue-based reference model of the buffered decoder.
module tb_instruction_decode_stage;
  localparam int PC_W  = 32;
  localparam int DEPTH = 2;
  localparam int CNT_W = 16;

  typedef struct packed {
    logic [3:0]      cond;
    logic [2:0]      cls;
    logic [3:0]      dp_op;
    logic            s;
    logic [3:0]      rn;
    logic [3:0]      rd;
    logic [3:0]      rm;
    logic [7:0]      shift;
    logic [3:0]      rot;
    logic [7:0]      imm8;
    logic [11:0]     off12;
    logic            ld;
    logic            up;
    logic [PC_W-1:0] pc;
    logic [PC_W-1:0] br;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic flush = 1'b0;
  int   total = 0;
  int   bad = 0;
  exp_t mq[$];

  instruction_decode_if #(.PC_W(PC_W)) bus ();

`ifdef DECODE_UNDEF_CNT_EN
  logic [CNT_W-1:0] undef_cnt;
  int unsigned      ucnt_model = 0;
`endif

  instruction_decode_stage #(.PC_W(PC_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .flush   (flush),
    .bus     (bus)
`ifdef DECODE_UNDEF_CNT_EN
    ,
    .undef_cnt (undef_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference decode, written directly from the instruction-set rules.
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [PC_W-1:0] pc);
    exp_t e;
    int unsigned top3;
    longint off;
    e = '0;
    e.cond = ins[31:28];
    e.pc = pc;
    top3 = ins[27:25];
    if (top3 == 0) e.cls = 3'd0;
    else if (top3 == 1) e.cls = 3'd1;
    else if (top3 == 2 || (top3 == 3 && ins[4] == 1'b0)) e.cls = 3'd2;
    else if (top3 == 5) e.cls = ins[24] ? 3'd4 : 3'd3;
    else e.cls = 3'd7;
    if (e.cls == 3'd0 || e.cls == 3'd1) begin
      e.dp_op = ins[24:21];
      e.s = ins[20];
      e.rn = ins[19:16];
      e.rd = ins[15:12];
    end
    if (e.cls == 3'd0 || e.cls == 3'd2) begin
      e.rm = ins[3:0];
      e.shift = ins[11:4];
    end
    if (e.cls == 3'd1) begin
      e.rot = ins[11:8];
      e.imm8 = ins[7:0];
    end
    if (e.cls == 3'd2) begin
      e.rn = ins[19:16];
      e.rd = ins[15:12];
      e.off12 = ins[11:0];
      e.ld = ins[20];
      e.up = ins[23];
    end
    if (e.cls == 3'd3 || e.cls == 3'd4) begin
      off = longint'(ins[23:0]);
      if (off >= 64'sd8388608) off = off - 64'sd16777216;
      e.br = PC_W'(longint'(pc) + 8 + off * 4);
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return {bus.out_cond, bus.out_class, bus.out_dp_op, bus.out_s, bus.out_rn, bus.out_rd,
            bus.out_rm, bus.out_shift, bus.out_rot, bus.out_imm8, bus.out_off12, bus.out_ld,
            bus.out_up, bus.out_pc, bus.out_br_target};
  endfunction

  function automatic exp_t model_head();
    return (mq.size() > 0) ? mq[0] : exp_t'('0);
  endfunction

  // Advance the model by one clock using the currently driven inputs, then the DUT.
  task automatic tick();
    bit do_push;
    bit do_pop;
    exp_t e;
    do_push = bus.in_valid && (mq.size() < DEPTH);
    do_pop  = (mq.size() > 0) && bus.out_ready;
    e = ref_decode(bus.in_instr, bus.in_pc);
    if (flush) begin
      mq.delete();
    end else begin
      if (do_pop) void'(mq.pop_front());
      if (do_push) begin
        mq.push_back(e);
`ifdef DECODE_UNDEF_CNT_EN
        if (e.cls == 3'd7 && ucnt_model < (2 ** CNT_W) - 1) ucnt_model++;
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit v, input logic [31:0] ins, input logic [PC_W-1:0] pc, input bit rdy);
    bus.in_valid = v;
    bus.in_instr = ins;
    bus.in_pc = pc;
    bus.out_ready = rdy;
  endtask

  task automatic test_reset();
    drive(0, '0, '0, 0);
    reset_n = 1'b0;
    #12;
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b exp=0", bus.out_valid); end
    total++;
    if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b exp=1", bus.in_ready); end
    total++;
    if (observed() !== exp_t'('0)) begin bad++; $display("FAIL reset_fields got=%h exp=0", observed()); end
`ifdef DECODE_UNDEF_CNT_EN
    total++;
    if (undef_cnt !== '0) begin bad++; $display("FAIL reset_undef_cnt got=%0d exp=0", undef_cnt); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    mq.delete();
  endtask

  task automatic test_dp_reg();
    drive(1, 32'hE0875006, 32'h0, 0);
    tick();
    drive(0, '0, '0, 0);
    total++;
    if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL dp_out_valid got=%0b exp=1", bus.out_valid); end
    total++;
    if ({bus.out_class, bus.out_dp_op, bus.out_cond, bus.out_rn, bus.out_rd, bus.out_rm} !== {3'd0, 4'd4, 4'hE, 4'd7, 4'd5, 4'd6}) begin
      bad++;
      $display("FAIL dp_fields got=%h exp=%h", {bus.out_class, bus.out_dp_op, bus.out_cond, bus.out_rn, bus.out_rd, bus.out_rm},
               {3'd0, 4'd4, 4'hE, 4'd7, 4'd5, 4'd6});
    end
    total++;
    if (observed() !== model_head()) begin bad++; $display("FAIL dp_all got=%h exp=%h", observed(), model_head()); end
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_branch();
    logic [31:0]     ins [3] = '{32'hEAFFFFFE, 32'hEB000000, 32'hEA000000};
    logic [PC_W-1:0] pcs [3] = '{32'h100, 32'h40, 32'hFFFFFFF8};
    logic [2:0]      cls [3] = '{3'd3, 3'd4, 3'd3};
    logic [PC_W-1:0] tgt [3] = '{32'h100, 32'h48, 32'h0};
    for (int i = 0; i < 3; i++) begin
      drive(1, ins[i], pcs[i], 0);
      tick();
      drive(0, '0, '0, 0);
      total++;
      if (bus.out_class !== cls[i]) begin bad++; $display("FAIL br_class[%0d] got=%0d exp=%0d", i, bus.out_class, cls[i]); end
      total++;
      if (bus.out_br_target !== tgt[i]) begin bad++; $display("FAIL br_target[%0d] got=%h exp=%h", i, bus.out_br_target, tgt[i]); end
      bus.out_ready = 1'b1;
      tick();
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [PC_W-1:0] pa = 32'h1000, pb = 32'h1004, pc = 32'h1008;
    drive(1, 32'hE2811001, pa, 0);
    tick();
    drive(1, 32'hE0822003, pb, 0);
    tick();
    drive(1, 32'hE5934008, pc, 0);
    total++;
    if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_full_ready got=%0b exp=0", bus.in_ready); end
    tick();
    total++;
    if (bus.out_pc !== pa || bus.in_ready !== 1'b0) begin bad++; $display("FAIL bp_hold got pc=%h rdy=%0b exp pc=%h rdy=0", bus.out_pc, bus.in_ready, pa); end
    bus.out_ready = 1'b1;
    tick();
    total++;
    if (bus.out_pc !== pb || bus.in_ready !== 1'b1) begin bad++; $display("FAIL bp_second got pc=%h rdy=%0b exp pc=%h rdy=1", bus.out_pc, bus.in_ready, pb); end
    tick();
    total++;
    if (bus.out_pc !== pc || bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_pushpop got pc=%h v=%0b rdy=%0b exp pc=%h v=1 rdy=1", bus.out_pc, bus.out_valid, bus.in_ready, pc);
    end
    total++;
    if (observed() !== model_head()) begin bad++; $display("FAIL bp_fields got=%h exp=%h", observed(), model_head()); end
    bus.in_valid = 1'b0;
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%0b exp=0", bus.out_valid); end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_flush();
    drive(1, 32'hE1A00000, 32'h2000, 0);
    tick();
    drive(1, 32'hE1A01001, 32'h2004, 0);
    tick();
    drive(1, 32'hE1A02002, 32'h2008, 0);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    drive(0, '0, '0, 0);
    total++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin bad++; $display("FAIL flush_state got v=%0b rdy=%0b exp v=0 rdy=1", bus.out_valid, bus.in_ready); end
    total++;
    if (observed() !== exp_t'('0)) begin bad++; $display("FAIL flush_fields got=%h exp=0", observed()); end
    tick();
    total++;
    if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL flush_dropped got=%0b exp=0", bus.out_valid); end
  endtask

  task automatic test_ldst_undef();
`ifdef DECODE_UNDEF_CNT_EN
    logic [CNT_W-1:0] before;
    before = undef_cnt;
`endif
    drive(1, 32'hE5912004, 32'h3000, 0);
    tick();
    drive(0, '0, '0, 0);
    total++;
    if ({bus.out_class, bus.out_ld, bus.out_rn, bus.out_rd, bus.out_off12} !== {3'd2, 1'b1, 4'd1, 4'd2, 12'd4}) begin
      bad++; $display("FAIL ldst_fields got=%h exp=%h", {bus.out_class, bus.out_ld, bus.out_rn, bus.out_rd, bus.out_off12}, {3'd2, 1'b1, 4'd1, 4'd2, 12'd4});
    end
    bus.out_ready = 1'b1;
    tick();
    drive(1, 32'hE7F000F0, 32'h3004, 0);
    tick();
    drive(0, '0, '0, 0);
    total++;
    if (bus.out_class !== 3'd7) begin bad++; $display("FAIL undef_class got=%0d exp=7", bus.out_class); end
    total++;
    if (observed() !== model_head()) begin bad++; $display("FAIL undef_fields got=%h exp=%h", observed(), model_head()); end
`ifdef DECODE_UNDEF_CNT_EN
    total++;
    if (undef_cnt !== before + CNT_W'(1)) begin bad++; $display("FAIL undef_cnt got=%0d exp=%0d", undef_cnt, before + CNT_W'(1)); end
`endif
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      logic [PC_W-1:0] pc;
      pc = ($urandom_range(0, 7) == 0) ? (32'hFFFFFF00 | ($urandom & 32'hFC)) : ($urandom & 32'hFFFFFFFC);
      drive($urandom_range(0, 3) != 0, $urandom, pc, $urandom_range(0, 2) != 0);
      flush = ($urandom_range(0, 31) == 0);
      total++;
      if (bus.out_valid !== (mq.size() > 0) || bus.in_ready !== (mq.size() < DEPTH)) begin
        bad++; $display("FAIL rnd_hs[%0d] got v=%0b rdy=%0b exp size=%0d", i, bus.out_valid, bus.in_ready, mq.size());
      end
      total++;
      if (observed() !== model_head()) begin bad++; $display("FAIL rnd_fields[%0d] got=%h exp=%h", i, observed(), model_head()); end
`ifdef DECODE_UNDEF_CNT_EN
      total++;
      if (undef_cnt !== CNT_W'(ucnt_model)) begin bad++; $display("FAIL rnd_undef_cnt[%0d] got=%0d exp=%0d", i, undef_cnt, ucnt_model); end
`endif
      tick();
    end
    flush = 1'b0;
    drive(0, '0, '0, 0);
  endtask

  initial begin
    test_reset();
    test_dp_reg();
    test_branch();
    test_backpressure();
    test_flush();
    test_ldst_undef();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
